// File: rtl/wb_burst_ram_if.sv
// Wishbone B3 bus bundle between a burst-capable master and the on-chip RAM responder.
interface wb_burst_ram_if #(
  parameter int unsigned Dw = 32
);
  localparam int unsigned SELw = Dw / 8;

  logic [31:0]     wb_adr_i;
  logic [Dw-1:0]   wb_dat_i;
  logic [SELw-1:0] wb_sel_i;
  logic            wb_we_i;
  logic            wb_cyc_i;
  logic            wb_stb_i;
  logic [2:0]      wb_cti_i;
  logic [1:0]      wb_bte_i;
  logic [Dw-1:0]   wb_dat_o;
  logic            wb_ack_o;
  logic            wb_err_o;
  logic            wb_rty_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    input  wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
    output wb_dat_o, wb_ack_o, wb_err_o, wb_rty_o
  );
endinterface

// File: rtl/wb_burst_ram_slave.sv
// Single-port on-chip RAM with a Wishbone B3 registered-feedback responder.
// Supports classic cycles plus CTI/BTE incrementing and wrap bursts at one beat per cycle.
module wb_burst_ram_slave #(
  parameter int unsigned Dw = 32,
  parameter int unsigned Aw = 12
) (
  input  logic           clk,
  input  logic           rst,
  wb_burst_ram_if.slave  wb
);

  localparam int unsigned SELw    = Dw / 8;
  localparam int unsigned Depth   = 1 << Aw;
  localparam logic [2:0]  CtiIncr = 3'b010;

  typedef enum logic [1:0] {
    IDLE,
    CLASSIC,
    BURST
  } state_e;

  state_e          state_q, state_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [Dw-1:0]   dat_q, dat_d;
  logic [Aw-1:0]   beat_adr_q, beat_adr_d;

  logic [Dw-1:0]   mem [Depth];

  logic            req;
  logic            oor;
  logic [Aw-1:0]   adr_lo;
  logic [Aw-1:0]   wrap_mask;
  logic [Aw-1:0]   beat_inc;
  logic [Aw-1:0]   next_adr;
  logic            lin_last;
  logic [Aw-1:0]   rd_adr;
  logic [Aw-1:0]   wr_adr;
  logic            wr_en;

  assign req    = wb.wb_cyc_i & wb.wb_stb_i;
  assign adr_lo = wb.wb_adr_i[Aw-1:0];
  assign oor    = |wb.wb_adr_i[31:Aw];

  // Ack is qualified by the live request so a master wait state never sees a stale ack.
  assign wb.wb_ack_o = ack_q & req;
  assign wb.wb_err_o = err_q;
  assign wb.wb_rty_o = 1'b0;
  assign wb.wb_dat_o = dat_q;

  // Next beat address: linear increments, wrapN rolls only the low log2(N) bits.
  always_comb begin
    wrap_mask = '1;
    beat_inc  = beat_adr_q + Aw'(1);
    case (wb.wb_bte_i)
      2'b01:   wrap_mask = Aw'(3);
      2'b10:   wrap_mask = Aw'(7);
      2'b11:   wrap_mask = Aw'(15);
      default: wrap_mask = '1;
    endcase
    next_adr = (beat_adr_q & ~wrap_mask) | (beat_inc & wrap_mask);
    lin_last = (wb.wb_bte_i == 2'b00) && (beat_adr_q == '1);
  end

  // Response FSM: next state, ack/err, beat address and RAM read/write addressing.
  always_comb begin
    state_d    = state_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    beat_adr_d = beat_adr_q;
    rd_adr     = adr_lo;
    wr_adr     = beat_adr_q;
    wr_en      = 1'b0;

    case (state_q)
      IDLE: begin
        // The cycle showing err is itself a response; the master has not yet reacted to it.
        if (req && !err_q) begin
          if (oor) begin
            err_d = 1'b1;
          end else if (wb.wb_cti_i == CtiIncr) begin
            ack_d      = 1'b1;
            beat_adr_d = adr_lo;
            state_d    = BURST;
          end else begin
            ack_d   = 1'b1;
            state_d = CLASSIC;
          end
        end
      end

      CLASSIC: begin
        wr_en   = ack_q & req & wb.wb_we_i;
        wr_adr  = adr_lo;
        state_d = IDLE;
      end

      BURST: begin
        rd_adr = beat_adr_q;
        if (!wb.wb_cyc_i) begin
          state_d = IDLE;
        end else if (!wb.wb_stb_i) begin
          ack_d = 1'b0;
        end else if (ack_q) begin
          wr_en = wb.wb_we_i;
          if (wb.wb_cti_i != CtiIncr) begin
            state_d = IDLE;
          end else if (lin_last) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end else begin
            ack_d      = 1'b1;
            beat_adr_d = next_adr;
            rd_adr     = next_adr;
          end
        end else begin
          ack_d = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase

    if (rst) begin
      wr_en = 1'b0;
    end
  end

  // Read port with write-through bypass so a same-word read sees the bytes written this edge.
  always_comb begin
    dat_d = mem[rd_adr];
    if (wr_en && (wr_adr == rd_adr)) begin
      for (int i = 0; i < int'(SELw); i++) begin
        if (wb.wb_sel_i[i]) begin
          dat_d[i*8 +: 8] = wb.wb_dat_i[i*8 +: 8];
        end
      end
    end
  end

  // Byte-masked RAM write; contents are intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < int'(SELw); i++) begin
        if (wb.wb_sel_i[i]) begin
          mem[wr_adr][i*8 +: 8] <= wb.wb_dat_i[i*8 +: 8];
        end
      end
    end
  end

  // State and response registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      dat_q      <= '0;
      beat_adr_q <= '0;
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      dat_q      <= dat_d;
      beat_adr_q <= beat_adr_d;
    end
  end

endmodule

// File: tb/tb_wb_burst_ram_slave.sv
// Directed testbench for wb_burst_ram_slave: classic, wrap/linear bursts, errors, byte lanes, reset.
module tb_wb_burst_ram_slave;

  logic clk = 1'b0;
  logic rst;

  wb_burst_ram_if #(.Dw(32)) bus ();

  wb_burst_ram_slave #(.Dw(32), .Aw(12)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (bus)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [31:0] wdata [16];
  logic [31:0] rdata [16];
  logic        ack_tr [40];
  int          beats;
  int          errs;
  int          ncyc;

  task automatic bus_idle();
    bus.wb_adr_i = '0;
    bus.wb_dat_i = '0;
    bus.wb_sel_i = '0;
    bus.wb_we_i  = 1'b0;
    bus.wb_cyc_i = 1'b0;
    bus.wb_stb_i = 1'b0;
    bus.wb_cti_i = 3'b000;
    bus.wb_bte_i = 2'b00;
  endtask

  // One classic cycle; lat counts clock edges from request to ack/err.
  task automatic classic(input logic [31:0] adr, input logic we, input logic [31:0] d,
                         input logic [3:0] sel, output logic [31:0] rd, output int lat,
                         output logic got_err, output logic got_ack);
    lat = -1; rd = '0; got_err = 1'b0; got_ack = 1'b0;
    bus.wb_adr_i = adr; bus.wb_we_i = we; bus.wb_dat_i = d; bus.wb_sel_i = sel;
    bus.wb_cti_i = 3'b000; bus.wb_bte_i = 2'b00; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.wb_ack_o || bus.wb_err_o) begin
        lat = i; rd = bus.wb_dat_o; got_err = bus.wb_err_o; got_ack = bus.wb_ack_o;
        break;
      end
    end
    @(posedge clk); #1;
    bus_idle();
  endtask

  // Burst master: data from wdata[], read data to rdata[]; optional stb gap after gap_after beats.
  task automatic burst_run(input logic [31:0] adr, input logic [1:0] bte, input logic we,
                           input int nbeats, input int gap_after, input int gap_len);
    int gapped;
    bit done;
    gapped = 0; done = 1'b0; beats = 0; errs = 0; ncyc = -1;
    for (int i = 0; i < 40; i++) ack_tr[i] = 1'b0;
    bus.wb_adr_i = adr; bus.wb_bte_i = bte; bus.wb_we_i = we; bus.wb_sel_i = 4'hF;
    bus.wb_dat_i = wdata[0];
    bus.wb_cti_i = (nbeats == 1) ? 3'b111 : 3'b010;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      ack_tr[c] = bus.wb_ack_o;
      if (bus.wb_err_o) begin
        errs++; done = 1'b1; ncyc = c + 1;
      end else if (bus.wb_ack_o) begin
        rdata[beats] = bus.wb_dat_o;
        beats++;
        if (beats == nbeats) begin done = 1'b1; ncyc = c + 1; end
      end
      @(posedge clk); #1;
      if (!done) begin
        if (beats == gap_after && gapped < gap_len) begin
          bus.wb_stb_i = 1'b0; gapped++;
        end else begin
          bus.wb_stb_i = 1'b1;
        end
        bus.wb_cti_i = (beats == nbeats - 1) ? 3'b111 : 3'b010;
        bus.wb_dat_i = wdata[beats];
      end
    end
    bus_idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_idle();
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++; if (bus.wb_ack_o !== 1'b0) begin tests_failed++; $display("FAIL reset_ack: got %b want 0", bus.wb_ack_o); end
    tests_run++; if (bus.wb_err_o !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b want 0", bus.wb_err_o); end
    tests_run++; if (bus.wb_dat_o !== 32'h0) begin tests_failed++; $display("FAIL reset_dat: got %h want 0", bus.wb_dat_o); end
    tests_run++; if (bus.wb_rty_o !== 1'b0) begin tests_failed++; $display("FAIL reset_rty: got %b want 0", bus.wb_rty_o); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_classic();
    logic [31:0] rd; int lat; logic e, a;
    classic(32'h10, 1'b1, 32'hDEADBEEF, 4'hF, rd, lat, e, a);
    tests_run++; if (lat !== 1 || e !== 1'b0) begin tests_failed++; $display("FAIL classic_wr_lat: got lat %0d err %b want 1/0", lat, e); end
    classic(32'h10, 1'b0, 32'h0, 4'hF, rd, lat, e, a);
    tests_run++; if (lat !== 1) begin tests_failed++; $display("FAIL classic_rd_lat: got %0d want 1", lat); end
    tests_run++; if (rd !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL classic_rd_dat: got %h want deadbeef", rd); end
  endtask

  task automatic test_back_to_back();
    logic exp_ack [5];
    exp_ack = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    bus.wb_adr_i = 32'h10; bus.wb_we_i = 1'b0; bus.wb_sel_i = 4'hF; bus.wb_cti_i = 3'b000;
    bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      tests_run++;
      if (bus.wb_ack_o !== exp_ack[c]) begin tests_failed++; $display("FAIL b2b_ack[%0d]: got %b want %b", c, bus.wb_ack_o, exp_ack[c]); end
      if (exp_ack[c]) begin
        tests_run++;
        if (bus.wb_dat_o !== 32'hDEADBEEF) begin tests_failed++; $display("FAIL b2b_dat[%0d]: got %h want deadbeef", c, bus.wb_dat_o); end
      end
    end
    bus_idle();
    @(posedge clk); #1;
  endtask

  task automatic test_wrap4();
    logic [31:0] rd; int lat; logic e, a;
    logic [31:0] exp_d [4];
    classic(32'h4, 1'b1, 32'hA0A0A0A0, 4'hF, rd, lat, e, a);
    classic(32'h5, 1'b1, 32'hB1B1B1B1, 4'hF, rd, lat, e, a);
    classic(32'h6, 1'b1, 32'hC2C2C2C2, 4'hF, rd, lat, e, a);
    classic(32'h7, 1'b1, 32'hD3D3D3D3, 4'hF, rd, lat, e, a);
    exp_d = '{32'hC2C2C2C2, 32'hD3D3D3D3, 32'hA0A0A0A0, 32'hB1B1B1B1};
    burst_run(32'h6, 2'b01, 1'b0, 4, -1, 0);
    tests_run++; if (ncyc !== 5 || beats !== 4) begin tests_failed++; $display("FAIL wrap4_timing: got cycles %0d beats %0d want 5/4", ncyc, beats); end
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (rdata[k] !== exp_d[k]) begin tests_failed++; $display("FAIL wrap4_dat[%0d]: got %h want %h", k, rdata[k], exp_d[k]); end
    end
  endtask

  task automatic test_linear_gap();
    for (int k = 0; k < 16; k++) wdata[k] = 32'h5A000020 + 32'(k) * 32'h00010001;
    burst_run(32'h20, 2'b00, 1'b1, 8, 3, 2);
    tests_run++; if (ncyc !== 12 || beats !== 8) begin tests_failed++; $display("FAIL lin_wr_timing: got cycles %0d beats %0d want 12/8", ncyc, beats); end
    tests_run++; if (ack_tr[4] !== 1'b0 || ack_tr[5] !== 1'b0 || ack_tr[6] !== 1'b0) begin
      tests_failed++; $display("FAIL lin_gap_ack: got %b%b%b want 000", ack_tr[4], ack_tr[5], ack_tr[6]);
    end
    burst_run(32'h20, 2'b00, 1'b0, 8, -1, 0);
    tests_run++; if (ncyc !== 9) begin tests_failed++; $display("FAIL lin_rd_timing: got %0d want 9", ncyc); end
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (rdata[k] !== wdata[k]) begin tests_failed++; $display("FAIL lin_rd_dat[%0d]: got %h want %h", k, rdata[k], wdata[k]); end
    end
  endtask

  task automatic test_wrap8();
    burst_run(32'h25, 2'b10, 1'b0, 8, -1, 0);
    tests_run++; if (ncyc !== 9 || beats !== 8) begin tests_failed++; $display("FAIL wrap8_timing: got cycles %0d beats %0d want 9/8", ncyc, beats); end
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (rdata[k] !== wdata[(k + 5) % 8]) begin tests_failed++; $display("FAIL wrap8_dat[%0d]: got %h want %h", k, rdata[k], wdata[(k + 5) % 8]); end
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] rd; int lat; logic e, a;
    classic(32'h1000, 1'b0, 32'h0, 4'hF, rd, lat, e, a);
    tests_run++; if (lat !== 1 || e !== 1'b1 || a !== 1'b0) begin
      tests_failed++; $display("FAIL oor_classic: got lat %0d err %b ack %b want 1/1/0", lat, e, a);
    end
    @(negedge clk);
    tests_run++; if (bus.wb_err_o !== 1'b0) begin tests_failed++; $display("FAIL oor_err_width: got %b want 0", bus.wb_err_o); end
    @(posedge clk); #1;
    burst_run(32'hFFE, 2'b00, 1'b0, 4, -1, 0);
    tests_run++; if (beats !== 2 || errs !== 1 || ncyc !== 4) begin
      tests_failed++; $display("FAIL oor_burst: got beats %0d errs %0d cycles %0d want 2/1/4", beats, errs, ncyc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_byte_sel();
    logic [31:0] rd; int lat; logic e, a;
    classic(32'h30, 1'b1, 32'h11223344, 4'hF, rd, lat, e, a);
    classic(32'h30, 1'b1, 32'hFFFFFFFF, 4'b0010, rd, lat, e, a);
    classic(32'h30, 1'b0, 32'h0, 4'hF, rd, lat, e, a);
    tests_run++; if (rd !== 32'h1122FF44) begin tests_failed++; $display("FAIL byte_sel: got %h want 1122ff44", rd); end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] rd; int lat; logic e, a;
    for (int k = 0; k < 4; k++) classic(32'h40 + 32'(k), 1'b1, 32'hC0DE0040 + 32'(k), 4'hF, rd, lat, e, a);
    bus.wb_adr_i = 32'h40; bus.wb_we_i = 1'b1; bus.wb_sel_i = 4'hF; bus.wb_bte_i = 2'b00;
    bus.wb_cti_i = 3'b010; bus.wb_dat_i = 32'h0BAD0000; bus.wb_cyc_i = 1'b1; bus.wb_stb_i = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    tests_run++; if (bus.wb_ack_o !== 1'b1) begin tests_failed++; $display("FAIL rst_burst_beat1: got %b want 1", bus.wb_ack_o); end
    @(posedge clk); #1;
    bus.wb_dat_i = 32'h0BAD0001;
    @(negedge clk);
    tests_run++; if (bus.wb_ack_o !== 1'b1) begin tests_failed++; $display("FAIL rst_burst_beat2: got %b want 1", bus.wb_ack_o); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    tests_run++; if (bus.wb_ack_o !== 1'b0 || bus.wb_err_o !== 1'b0) begin
      tests_failed++; $display("FAIL rst_burst_resp: got ack %b err %b want 0/0", bus.wb_ack_o, bus.wb_err_o);
    end
    bus_idle();
    @(posedge clk); #1;
    classic(32'h41, 1'b0, 32'h0, 4'hF, rd, lat, e, a);
    tests_run++; if (rd !== 32'hC0DE0041) begin tests_failed++; $display("FAIL rst_burst_beat2_word: got %h want c0de0041", rd); end
    classic(32'h40, 1'b0, 32'h0, 4'hF, rd, lat, e, a);
    tests_run++; if (rd !== 32'h0BAD0000) begin tests_failed++; $display("FAIL rst_burst_beat1_word: got %h want 0bad0000", rd); end
  endtask

  initial begin
    for (int k = 0; k < 16; k++) wdata[k] = '0;
    test_reset();
    test_classic();
    test_back_to_back();
    test_wrap4();
    test_linear_gap();
    test_wrap8();
    test_out_of_range();
    test_byte_sel();
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
